vga_frame_renderer: RTL and testbench

- Downstream consumer of the game-logic block. Takes ball and platform geometry plus the game-over flag and drives an 800x600@72 Hz VGA output (pixel clock = 50 MHz system clk).
- Owns horizontal/vertical timing counters, a per-frame geometry snapshot, and a 2-stage pixel pipeline producing 8-bit RGB332 with aligned sync.

---
 rtl/vga_frame_renderer.sv | 215 +++++++++++++++++++++
 tb/tb_vga_frame_renderer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_renderer.sv
// VGA renderer: 800x600@72 timing, per-frame geometry snapshot and a two-stage
// pixel pipeline producing RGB332 with sync aligned to the pixel data.

module vga_frame_renderer #(
    parameter int unsigned BALL_R    = 20,
    parameter int unsigned PLAT_H    = 8,
    parameter int unsigned HOR_SHIFT = 3,
    parameter logic [7:0]  COL_BG    = 8'b000_000_10,
    parameter logic [7:0]  COL_OVER  = 8'b111_000_00,
    parameter logic [7:0]  COL_PLAT  = 8'b000_111_00,
    parameter logic [7:0]  COL_BALL  = 8'b111_111_00,
    parameter int unsigned H_VIS     = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_VIS     = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_ver,
    input  logic [6:0] ball_hor,
    input  logic [7:0] platform0_ver,
    input  logic [6:0] platform0_hor,
    input  logic [5:0] platform0_width,
    input  logic [6:0] platform1_ver,
    input  logic [6:0] platform1_hor,
    input  logic [4:0] platform1_width,
    input  logic [5:0] platform2_ver,
    input  logic [6:0] platform2_hor,
    input  logic [4:0] platform2_width,
    input  logic [4:0] platform3_ver,
    input  logic [6:0] platform3_hor,
    input  logic [4:0] platform3_width,
    input  logic [7:0] out_platform_ver,
    input  logic [6:0] out_platform_hor,
    input  logic [5:0] out_platform_width,
    input  logic       over,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_tick
);

    localparam int unsigned HTotal = H_VIS + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VIS + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] HLast      = 11'(HTotal - 1);
    localparam logic [10:0] HVis       = 11'(H_VIS);
    localparam logic [10:0] HSyncStart = 11'(H_VIS + H_FRONT);
    localparam logic [10:0] HSyncEnd   = 11'(H_VIS + H_FRONT + H_SYNC);
    localparam logic [9:0]  VLast      = 10'(VTotal - 1);
    localparam logic [9:0]  VVis       = 10'(V_VIS);
    localparam logic [9:0]  VSyncStart = 10'(V_VIS + V_FRONT);
    localparam logic [9:0]  VSyncEnd   = 10'(V_VIS + V_FRONT + V_SYNC);

    localparam logic signed [11:0] BallR   = 12'(BALL_R);
    localparam logic signed [11:0] PlatBot = 12'(PLAT_H - 1);
    localparam logic signed [11:0] XMax    = 12'(H_VIS - 1);
    localparam logic signed [11:0] Zero    = 12'sd0;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        snap_en;

    logic            over_q, over_d;
    logic [9:0]      ball_ver_q, ball_ver_d;
    logic [6:0]      ball_hor_q, ball_hor_d;
    logic [4:0][7:0] plat_ver_q, plat_ver_d, plat_ver_in;
    logic [4:0][6:0] plat_hor_q, plat_hor_d, plat_hor_in;
    logic [4:0][5:0] plat_wid_q, plat_wid_d, plat_wid_in;

    logic frame_tick_q, frame_tick_d;
    logic vis_q, vis_d, ball_hit_q, ball_hit_d, plat_hit_q, plat_hit_d;
    logic hs1_q, hs1_d, vs1_q, vs1_d;
    logic [7:0] rgb_q, rgb_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d;

    logic signed [11:0] px, py, bx, by;

    // Platform rows are in units of 4 px; x bounds are clipped to the visible line.
    function automatic logic plat_covers(input logic signed [11:0] x,
                                         input logic signed [11:0] y,
                                         input logic [7:0] ver,
                                         input logic [6:0] hor,
                                         input logic [5:0] wid);
        logic signed [11:0] top, left, right;
        top   = signed'(12'(ver) << 2);
        left  = (signed'(12'(hor)) - signed'(12'(wid))) <<< HOR_SHIFT;
        right = (signed'(12'(hor)) + signed'(12'(wid))) <<< HOR_SHIFT;
        if (left < Zero) left = Zero;
        if (right > XMax) right = XMax;
        return (y >= top) && (y <= top + PlatBot) && (x >= left) && (x <= right);
    endfunction

    always_comb begin
        plat_ver_in[0] = platform0_ver;
        plat_ver_in[1] = {1'b0, platform1_ver};
        plat_ver_in[2] = {2'b0, platform2_ver};
        plat_ver_in[3] = {3'b0, platform3_ver};
        plat_ver_in[4] = out_platform_ver;
        plat_hor_in[0] = platform0_hor;
        plat_hor_in[1] = platform1_hor;
        plat_hor_in[2] = platform2_hor;
        plat_hor_in[3] = platform3_hor;
        plat_hor_in[4] = out_platform_hor;
        plat_wid_in[0] = platform0_width;
        plat_wid_in[1] = {1'b0, platform1_width};
        plat_wid_in[2] = {1'b0, platform2_width};
        plat_wid_in[3] = {1'b0, platform3_width};
        plat_wid_in[4] = out_platform_width;
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Geometry is latched once per frame at the start of vertical blanking.
    assign snap_en = (h_cnt_q == '0) && (v_cnt_q == VVis);

    always_comb begin
        over_d       = snap_en ? over        : over_q;
        ball_ver_d   = snap_en ? ball_ver    : ball_ver_q;
        ball_hor_d   = snap_en ? ball_hor    : ball_hor_q;
        plat_ver_d   = snap_en ? plat_ver_in : plat_ver_q;
        plat_hor_d   = snap_en ? plat_hor_in : plat_hor_q;
        plat_wid_d   = snap_en ? plat_wid_in : plat_wid_q;
        frame_tick_d = snap_en;
    end

    assign px = signed'({1'b0, h_cnt_q});
    assign py = signed'({2'b0, v_cnt_q});
    assign bx = signed'(12'(ball_hor_q)) <<< HOR_SHIFT;
    assign by = signed'({2'b0, ball_ver_q});

    always_comb begin
        vis_d      = (h_cnt_q < HVis) && (v_cnt_q < VVis);
        ball_hit_d = (px >= bx - BallR) && (px <= bx + BallR) &&
                     (py >= by - BallR) && (py <= by + BallR);
        plat_hit_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            plat_hit_d = plat_hit_d |
                         plat_covers(px, py, plat_ver_q[i], plat_hor_q[i], plat_wid_q[i]);
        end
        hs1_d = (h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd);
        vs1_d = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);
    end

    always_comb begin
        if (!vis_q) begin
            rgb_d = 8'h00;
        end else if (ball_hit_q) begin
            rgb_d = COL_BALL;
        end else if (plat_hit_q) begin
            rgb_d = COL_PLAT;
        end else begin
            rgb_d = over_q ? COL_OVER : COL_BG;
        end
        hsync_d = hs1_q;
        vsync_d = vs1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            over_q       <= 1'b0;
            ball_ver_q   <= '0;
            ball_hor_q   <= '0;
            plat_ver_q   <= '0;
            plat_hor_q   <= '0;
            plat_wid_q   <= '0;
            frame_tick_q <= 1'b0;
            vis_q        <= 1'b0;
            ball_hit_q   <= 1'b0;
            plat_hit_q   <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            rgb_q        <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            over_q       <= over_d;
            ball_ver_q   <= ball_ver_d;
            ball_hor_q   <= ball_hor_d;
            plat_ver_q   <= plat_ver_d;
            plat_hor_q   <= plat_hor_d;
            plat_wid_q   <= plat_wid_d;
            frame_tick_q <= frame_tick_d;
            vis_q        <= vis_d;
            ball_hit_q   <= ball_hit_d;
            plat_hit_q   <= plat_hit_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_frame_renderer.sv
// Bench for vga_frame_renderer: a shrunk-timing instance for multi-frame behaviour
// and a default-timing instance for the real line timing and first-frame pixels.

module tb_vga_frame_renderer;

    localparam int HT        = 232;
    localparam int VT        = 31;
    localparam int FR        = HT * VT;
    localparam int FHT       = 1040;
    localparam int HS_RISE   = 208 + 2;
    localparam int HS_W      = 16;
    localparam int VS_RISE   = 26 * HT + 2;
    localparam int VS_W      = 3 * HT;
    localparam int TICK_CYC  = 24 * HT + 1;
    localparam int FHS_RISE  = 856 + 2;
    localparam int FHS_W     = 120;
    localparam int N_END     = 5 * FR + 10 * HT + 50 + 2;

    localparam logic [7:0] BG = 8'h02;
    localparam logic [7:0] OV = 8'hE0;
    localparam logic [7:0] PL = 8'h1C;
    localparam logic [7:0] BA = 8'hFC;

    typedef struct packed {
        logic            over;
        logic [9:0]      bv;
        logic [6:0]      bh;
        logic [4:0][7:0] pv;
        logic [4:0][6:0] ph;
        logic [4:0][5:0] pw;
    } geom_t;

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic       clk, rst;
    logic [9:0] ball_ver;
    logic [6:0] ball_hor;
    logic [7:0] p0v; logic [6:0] p0h; logic [5:0] p0w;
    logic [6:0] p1v; logic [6:0] p1h; logic [4:0] p1w;
    logic [5:0] p2v; logic [6:0] p2h; logic [4:0] p2w;
    logic [4:0] p3v; logic [6:0] p3h; logic [4:0] p3w;
    logic [7:0] opv; logic [6:0] oph; logic [5:0] opw;
    logic       over;
    logic       s_hs, s_vs, s_tick, f_hs, f_vs, f_tick;
    logic [7:0] s_rgb, f_rgb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    vec_t  vecs[$];
    geom_t geoms[5];

    logic s_hs_prev = 0, s_vs_prev = 0, s_tick_prev = 0, f_hs_prev = 0;
    int   s_hs_rise = 0, s_vs_rise = 0, s_tick_rise = 0, f_hs_rise = 0;
    int   s_hs_n = 0, s_vs_n = 0, s_tick_n = 0, f_hs_n = 0;

    vga_frame_renderer #(
        .BALL_R(4), .H_VIS(200), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
        .V_VIS(24), .V_FRONT(2), .V_SYNC(3), .V_BACK(2)
    ) dut_s (
        .clk(clk), .rst(rst), .ball_ver(ball_ver), .ball_hor(ball_hor),
        .platform0_ver(p0v), .platform0_hor(p0h), .platform0_width(p0w),
        .platform1_ver(p1v), .platform1_hor(p1h), .platform1_width(p1w),
        .platform2_ver(p2v), .platform2_hor(p2h), .platform2_width(p2w),
        .platform3_ver(p3v), .platform3_hor(p3h), .platform3_width(p3w),
        .out_platform_ver(opv), .out_platform_hor(oph), .out_platform_width(opw),
        .over(over), .hsync(s_hs), .vsync(s_vs), .rgb(s_rgb), .frame_tick(s_tick)
    );

    vga_frame_renderer dut_f (
        .clk(clk), .rst(rst), .ball_ver(ball_ver), .ball_hor(ball_hor),
        .platform0_ver(p0v), .platform0_hor(p0h), .platform0_width(p0w),
        .platform1_ver(p1v), .platform1_hor(p1h), .platform1_width(p1w),
        .platform2_ver(p2v), .platform2_hor(p2h), .platform2_width(p2w),
        .platform3_ver(p3v), .platform3_hor(p3h), .platform3_width(p3w),
        .out_platform_ver(opv), .out_platform_hor(oph), .out_platform_width(opw),
        .over(over), .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb), .frame_tick(f_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic geom_t g_off();
        geom_t g;
        g = '0;
        g.bv = 10'd900;
        for (int i = 0; i < 5; i++) g.pv[i] = 8'hFF;
        return g;
    endfunction

    task automatic apply(input geom_t g);
        over = g.over; ball_ver = g.bv; ball_hor = g.bh;
        p0v = g.pv[0];      p0h = g.ph[0]; p0w = g.pw[0];
        p1v = g.pv[1][6:0]; p1h = g.ph[1]; p1w = g.pw[1][4:0];
        p2v = g.pv[2][5:0]; p2h = g.ph[2]; p2w = g.pw[2][4:0];
        p3v = g.pv[3][4:0]; p3h = g.ph[3]; p3w = g.pw[3][4:0];
        opv = g.pv[4];      oph = g.ph[4]; opw = g.pw[4];
    endtask

    task automatic add(input int dut, input int f, input int v, input int h,
                       input logic [7:0] e, input string n);
        vec_t t;
        t.dut  = dut;
        t.cyc  = (dut == 0) ? f * FR + v * HT + h + 2 : v * FHT + h + 2;
        t.exp  = e;
        t.name = n;
        vecs.push_back(t);
    endtask

    // One clock of the main run: edge monitors, pixel vectors, geometry updates.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_hs && !s_hs_prev) begin
            s_hs_n++; s_hs_rise = cyc;
            chk("hsync_rise_phase", (cyc - HS_RISE) % HT, 0);
        end
        if (!s_hs && s_hs_prev) chk("hsync_width", cyc - s_hs_rise, HS_W);
        if (s_vs && !s_vs_prev) begin
            s_vs_n++; s_vs_rise = cyc;
            chk("vsync_rise_phase", (cyc - VS_RISE) % FR, 0);
        end
        if (!s_vs && s_vs_prev) chk("vsync_width", cyc - s_vs_rise, VS_W);
        if (s_tick && !s_tick_prev) begin
            s_tick_n++; s_tick_rise = cyc;
            chk("tick_phase", (cyc - TICK_CYC) % FR, 0);
        end
        if (!s_tick && s_tick_prev) chk("tick_width", cyc - s_tick_rise, 1);
        if (f_hs && !f_hs_prev) begin
            f_hs_n++; f_hs_rise = cyc;
            chk("full_hsync_rise_phase", (cyc - FHS_RISE) % FHT, 0);
        end
        if (!f_hs && f_hs_prev) chk("full_hsync_width", cyc - f_hs_rise, FHS_W);
        s_hs_prev = s_hs; s_vs_prev = s_vs; s_tick_prev = s_tick; f_hs_prev = f_hs;
        foreach (vecs[i]) begin
            if (vecs[i].cyc == cyc)
                chk(vecs[i].name, (vecs[i].dut == 0) ? int'(s_rgb) : int'(f_rgb),
                    int'(vecs[i].exp));
        end
        // Next frame's geometry changes mid-frame; the current frame must not tear.
        for (int f = 1; f < 5; f++) begin
            if (cyc == (f - 1) * FR + 2 * HT) apply(geoms[f]);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) geoms[i] = g_off();
        geoms[1].bv = 10'd12; geoms[1].bh = 7'd10;
        geoms[1].pv[0] = 8'd4; geoms[1].ph[0] = 7'd12; geoms[1].pw[0] = 6'd9;
        geoms[2].bv = 10'd0; geoms[2].bh = 7'd0;
        geoms[2].pv[1] = 8'd1; geoms[2].ph[1] = 7'd2;  geoms[2].pw[1] = 6'd9;
        geoms[2].pv[2] = 8'd3; geoms[2].ph[2] = 7'd20; geoms[2].pw[2] = 6'd10;
        geoms[2].pv[3] = 8'd4; geoms[2].ph[3] = 7'd2;  geoms[2].pw[3] = 6'd1;
        geoms[2].pv[4] = 8'd5; geoms[2].ph[4] = 7'd25; geoms[2].pw[4] = 6'd1;
        geoms[3].over = 1'b1;

        // Frame 0: zero snapshot -> ball around (0,0), zero-width platforms on rows 0-7.
        add(0, 0, 0, 0, BA, "f0_ball_origin");   add(0, 0, 0, 4, BA, "f0_ball_xedge");
        add(0, 0, 0, 5, BG, "f0_past_ball");     add(0, 0, 4, 0, BA, "f0_ball_yedge");
        add(0, 0, 5, 0, PL, "f0_plat_x0");       add(0, 0, 5, 1, BG, "f0_plat_x1");
        add(0, 0, 8, 0, BG, "f0_below_plat");    add(0, 0, 0, 200, 8'h00, "f0_hblank");
        add(0, 0, 24, 0, 8'h00, "f0_vblank");
        // Frame 1: ball x 76..84 y 8..16, platform0 rows 16..23 x 24..168.
        add(0, 1, 0, 0, BG, "f1_origin_bg");     add(0, 1, 12, 75, BG, "f1_ball_left_out");
        add(0, 1, 12, 76, BA, "f1_ball_left");   add(0, 1, 12, 84, BA, "f1_ball_right");
        add(0, 1, 12, 85, BG, "f1_ball_right_out");
        add(0, 1, 7, 80, BG, "f1_ball_top_out"); add(0, 1, 8, 80, BA, "f1_ball_top");
        add(0, 1, 16, 80, BA, "f1_ball_over_plat");
        add(0, 1, 16, 85, PL, "f1_plat_mid");    add(0, 1, 16, 24, PL, "f1_plat_left");
        add(0, 1, 16, 23, BG, "f1_plat_left_out");
        add(0, 1, 16, 168, PL, "f1_plat_right"); add(0, 1, 16, 169, BG, "f1_plat_right_out");
        add(0, 1, 17, 80, PL, "f1_plat_under_ball");
        add(0, 1, 23, 100, PL, "f1_plat_bottom");
        add(0, 1, 15, 100, BG, "f1_plat_top_out");
        add(0, 1, 12, 210, 8'h00, "f1_sync_blank");
        // Frame 2: clipping, negative ball coordinates, all five platforms.
        add(0, 2, 0, 0, BA, "f2_ball_neg");      add(0, 2, 0, 5, BG, "f2_ball_neg_edge");
        add(0, 2, 4, 0, BA, "f2_ball_over_p1");  add(0, 2, 5, 0, PL, "f2_p1_clip_left");
        add(0, 2, 5, 88, PL, "f2_p1_right");     add(0, 2, 5, 89, BG, "f2_p1_right_out");
        add(0, 2, 11, 50, PL, "f2_p1_bottom");   add(0, 2, 12, 79, BG, "f2_p2_left_out");
        add(0, 2, 12, 80, PL, "f2_p2_left");     add(0, 2, 12, 199, PL, "f2_p2_clip_right");
        add(0, 2, 16, 8, PL, "f2_p3_left");      add(0, 2, 16, 7, BG, "f2_p3_left_out");
        add(0, 2, 16, 24, PL, "f2_p3_right");    add(0, 2, 16, 25, BG, "f2_p3_right_out");
        add(0, 2, 20, 192, PL, "f2_out_left");   add(0, 2, 20, 191, BG, "f2_out_left_out");
        add(0, 2, 23, 199, PL, "f2_out_clip");
        // Frames 3-5: over=1 for exactly one snapshot.
        add(0, 3, 10, 50, OV, "f3_over_bg");     add(0, 3, 0, 0, OV, "f3_over_origin");
        add(0, 3, 0, 199, OV, "f3_over_last");   add(0, 3, 0, 200, 8'h00, "f3_over_blank");
        add(0, 4, 10, 50, BG, "f4_bg_back");     add(0, 4, 0, 0, BG, "f4_origin_bg");
        add(0, 5, 10, 50, BG, "f5_bg");
        // Default-timing instance, first frame only.
        add(1, 0, 0, 0, BA, "full_ball_origin"); add(1, 0, 0, 20, BA, "full_ball_xedge");
        add(1, 0, 0, 21, BG, "full_past_ball");  add(1, 0, 0, 799, BG, "full_last_px");
        add(1, 0, 0, 800, 8'h00, "full_hblank"); add(1, 0, 20, 5, BA, "full_ball_yedge");
        add(1, 0, 21, 0, BG, "full_below_ball"); add(1, 0, 5, 0, BA, "full_ball_over_plat");

        rst = 1'b0;
        apply(geoms[0]);
        #23;
        chk("reset_rgb", s_rgb, 0);
        chk("reset_hsync", s_hs, 0);
        chk("reset_vsync", s_vs, 0);
        chk("reset_tick", s_tick, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        while (cyc < N_END) step();

        chk("hsync_rise_count", s_hs_n, (N_END - HS_RISE) / HT + 1);
        chk("vsync_rise_count", s_vs_n, (N_END - VS_RISE) / FR + 1);
        chk("tick_count", s_tick_n, (N_END - TICK_CYC) / FR + 1);
        chk("full_hsync_rise_count", f_hs_n, (N_END - FHS_RISE) / FHT + 1);

        // Mid-line reset: outputs clear asynchronously, snapshot returns to zero.
        #2;
        rst = 1'b0;
        apply(geoms[1]);
        #1;
        chk("midreset_rgb", s_rgb, 0);
        chk("midreset_full_rgb", f_rgb, 0);
        chk("midreset_hsync", s_hs, 0);
        chk("midreset_vsync", s_vs, 0);
        chk("midreset_tick", s_tick, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        run_to(2);
        chk("rerun_ball_origin", s_rgb, BA);
        chk("rerun_full_ball_origin", f_rgb, BA);
        run_to(HS_RISE - 1);
        chk("rerun_hsync_low", s_hs, 0);
        run_to(HS_RISE);
        chk("rerun_hsync_high", s_hs, 1);
        run_to(5 * HT + 2);
        chk("rerun_plat_x0", s_rgb, PL);
        run_to(5 * HT + 3);
        chk("rerun_plat_x1", s_rgb, BG);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
